ix_arb16: RTL

Round-robin arbiter that shares one 16-bit I-X bus master port (the upstream side of the 16-bit clock-crossing bridge) between NM requesters. It accepts one transaction per requester into a per-requester pending slot and serialises the slots onto the shared port. It returns read data and acknowledges to the owning requester. The block sits entirely in the ix_clk domain, between the CPU/DMA/video requesters and the bridge.

---
 rtl/ix_arb_pkg.sv | 15 +
 rtl/ix_arb_pick.sv | 31 +++
 rtl/ix_arb16.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ix_arb_pkg.sv
// ix_arb_pkg: shared constants for the ix_arb16 requester arbiter.
// FSM state encodings, requester limit and an index-width helper.
package ix_arb_pkg;

  localparam int NM_MAX = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ix_arb_pick.sv
// ix_arb_pick: combinational cyclic priority picker.
// Ports: pend_i (pending mask), ptr_i (search start),
//        grant_o (first pending index at/after ptr), any_o (some pending).
module ix_arb_pick #(
  parameter int NM = 4,
  parameter int GW = 2
) (
  input  logic [NM-1:0] pend_i,
  input  logic [GW-1:0] ptr_i,
  output logic [GW-1:0] grant_o,
  output logic          any_o
);

  // Walk from the farthest offset back to ptr so the
  // nearest pending index is the last (winning) write.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = NM - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NM) idx = idx - NM;
      if (pend_i[idx]) begin
        grant_o = GW'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ix_arb16.sv
// ix_arb16: round-robin arbiter sharing one 16-bit I-X master port
// between NM requesters, one pending slot per requester.
// Ports: ix_clk/ix_rst_n (async active-low);
//   m_addr/m_wdata/m_be/m_rd/m_req  requester slices, slice i = requester i
//   m_busy/m_ack/m_rdata/m_err      requester status and read return
//   ox_addr/ox_wdata/ox_be/ox_rd/ox_req  shared-port request
//   ox_rdata/ox_busy/ox_ack/ox_err       shared-port response
// Build option: ARB_FIXED_PRI_EN selects fixed priority (requester 0
// highest) instead of round-robin.
module ix_arb16 #(
  parameter int NM = 4,
  parameter int AW = 32,
  parameter int DW = 16,
  parameter int BW = 2
) (
  input  logic             ix_clk,
  input  logic             ix_rst_n,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  input  logic [NM*BW-1:0] m_be,
  input  logic [NM-1:0]    m_rd,
  input  logic [NM-1:0]    m_req,
  output logic [NM-1:0]    m_busy,
  output logic [NM-1:0]    m_ack,
  output logic [DW-1:0]    m_rdata,
  output logic [NM-1:0]    m_err,
  output logic [AW-1:0]    ox_addr,
  output logic [DW-1:0]    ox_wdata,
  output logic [BW-1:0]    ox_be,
  output logic             ox_rd,
  output logic             ox_req,
  input  logic [DW-1:0]    ox_rdata,
  input  logic             ox_busy,
  input  logic             ox_ack,
  input  logic             ox_err
);

  import ix_arb_pkg::*;

  localparam int GW = idx_w(NM);

  logic [AW-1:0] addr_q  [NM];
  logic [DW-1:0] wdata_q [NM];
  logic [BW-1:0] be_q    [NM];
  logic [NM-1:0] rd_q;
  logic [NM-1:0] pend_q;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [NM-1:0] rack_q, rack_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [GW-1:0] pick_ptr;
  logic [GW-1:0] pick_grant;
  logic          pick_any;

  logic [NM-1:0] cap;
  logic [NM-1:0] done;
  logic [NM-1:0] gnt_oh;
  logic          wait_exit;
  logic          active;

  assign gnt_oh    = NM'(1) << grant_q;
  assign wait_exit = (state_q == ST_WAIT) && !ox_busy;
  assign done      = wait_exit ? gnt_oh : '0;

  // A busy slot ignores further requests until it drains.
  assign cap = m_req & ~pend_q;

`ifdef ARB_FIXED_PRI_EN
  assign pick_ptr = '0;
`else
  assign pick_ptr = ptr_q;
`endif

  ix_arb_pick #(
    .NM (NM),
    .GW (GW)
  ) u_pick (
    .pend_i  (pend_q),
    .ptr_i   (pick_ptr),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  always_ff @(posedge ix_clk or negedge ix_rst_n) begin
    if (!ix_rst_n) begin
      for (int i = 0; i < NM; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      rd_q   <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (cap[i]) begin
          addr_q[i]  <= m_addr[i*AW +: AW];
          wdata_q[i] <= m_wdata[i*DW +: DW];
          be_q[i]    <= m_be[i*BW +: BW];
          rd_q[i]    <= m_rd[i];
        end
      end
      // cap and done never hit the same slot: done needs pend set.
      pend_q <= (pend_q & ~done) | cap;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    rack_d  = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ox_ack && rd_q[grant_q]) begin
          rdata_d = ox_rdata;
          rack_d  = gnt_oh;
        end
        if (!ox_busy) begin
          state_d = ST_IDLE;
`ifndef ARB_FIXED_PRI_EN
          ptr_d = (grant_q == GW'(NM - 1)) ?
                  '0 : grant_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ix_clk or negedge ix_rst_n) begin
    if (!ix_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      rack_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rack_q  <= rack_d;
      rdata_q <= rdata_d;
    end
  end

  assign active   = (state_q != ST_IDLE);
  assign ox_req   = (state_q == ST_REQ);
  assign ox_addr  = active ? addr_q[grant_q]  : '0;
  assign ox_wdata = active ? wdata_q[grant_q] : '0;
  assign ox_be    = active ? be_q[grant_q]    : '0;
  assign ox_rd    = active ? rd_q[grant_q]    : 1'b0;

  // Writes are posted: acked on acceptance, never on completion.
  assign m_ack   = (m_req & ~m_rd & ~pend_q) | rack_q;
  assign m_busy  = pend_q;
  assign m_rdata = rdata_q;
  assign m_err   = {NM{ox_err}};

endmodule
